// File: rtl/mem_arbiter_if.sv
// Request/response/memory signal bundle between two requesters, the arbiter and the memory.
interface mem_arbiter_if #(
   parameter int unsigned AWIDTH = 16,
   parameter int unsigned DWIDTH = 16
);
   // port 0 request / response
   logic              req0_valid;
   logic              req0_we;
   logic              req0_lock;
   logic [AWIDTH-1:0] req0_addr;
   logic [DWIDTH-1:0] req0_wdata;
   logic              req0_ready;
   logic              rsp0_valid;
   logic [DWIDTH-1:0] rsp0_rdata;

   // port 1 request / response
   logic              req1_valid;
   logic              req1_we;
   logic              req1_lock;
   logic [AWIDTH-1:0] req1_addr;
   logic [DWIDTH-1:0] req1_wdata;
   logic              req1_ready;
   logic              rsp1_valid;
   logic [DWIDTH-1:0] rsp1_rdata;

   // shared memory side
   logic              mem_re;
   logic [AWIDTH-1:0] mem_raddr;
   logic [DWIDTH-1:0] mem_rdata;
   logic              mem_we;
   logic [AWIDTH-1:0] mem_waddr;
   logic [DWIDTH-1:0] mem_wdata;

   // arbiter side
   modport slave (
      input  req0_valid, req0_we, req0_lock, req0_addr, req0_wdata,
      output req0_ready, rsp0_valid, rsp0_rdata,
      input  req1_valid, req1_we, req1_lock, req1_addr, req1_wdata,
      output req1_ready, rsp1_valid, rsp1_rdata,
      output mem_re, mem_raddr, mem_we, mem_waddr, mem_wdata,
      input  mem_rdata
   );

   // requester/memory side
   modport master (
      output req0_valid, req0_we, req0_lock, req0_addr, req0_wdata,
      input  req0_ready, rsp0_valid, rsp0_rdata,
      output req1_valid, req1_we, req1_lock, req1_addr, req1_wdata,
      input  req1_ready, rsp1_valid, rsp1_rdata,
      input  mem_re, mem_raddr, mem_we, mem_waddr, mem_wdata,
      output mem_rdata
   );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter for a synchronous memory with lock support
// and read-response routing back to the issuing port.
module mem_arbiter #(
   parameter int unsigned AWIDTH = 16,
   parameter int unsigned DWIDTH = 16
) (
   input  logic         clk,
   input  logic         rst,
   mem_arbiter_if.slave bus
);

   // arbitration / lock / read-tracking state
   logic last_gnt,    last_gnt_nxt;
   logic lock_active, lock_active_nxt;
   logic lock_owner,  lock_owner_nxt;
   logic rd_pend,     rd_pend_nxt;
   logic rd_owner,    rd_owner_nxt;

   // current-cycle grant and the granted port's request fields
   logic              gnt_any;
   logic              gnt_port;
   logic              sel_we;
   logic              sel_lock;
   logic [AWIDTH-1:0] sel_addr;
   logic [DWIDTH-1:0] sel_wdata;
   logic              owner_lock;

   // State register; reset makes port 0 win the first tie and drops lock and pending reads.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_gnt    <= 1'b1;
         lock_active <= 1'b0;
         lock_owner  <= 1'b0;
         rd_pend     <= 1'b0;
         rd_owner    <= 1'b0;
      end else begin
         last_gnt    <= last_gnt_nxt;
         lock_active <= lock_active_nxt;
         lock_owner  <= lock_owner_nxt;
         rd_pend     <= rd_pend_nxt;
         rd_owner    <= rd_owner_nxt;
      end
   end

   // Arbitration and next-state: lock owner is exclusive, otherwise round-robin on ties.
   always_comb begin
      gnt_any         = 1'b0;
      gnt_port        = 1'b0;
      last_gnt_nxt    = last_gnt;
      lock_active_nxt = lock_active;
      lock_owner_nxt  = lock_owner;
      rd_pend_nxt     = 1'b0;
      rd_owner_nxt    = rd_owner;

      if (lock_active) begin
         if (!lock_owner && bus.req0_valid) begin
            gnt_any  = 1'b1;
            gnt_port = 1'b0;
         end else if (lock_owner && bus.req1_valid) begin
            gnt_any  = 1'b1;
            gnt_port = 1'b1;
         end
      end else if (bus.req0_valid && bus.req1_valid) begin
         gnt_any  = 1'b1;
         gnt_port = ~last_gnt;
      end else if (bus.req0_valid) begin
         gnt_any  = 1'b1;
         gnt_port = 1'b0;
      end else if (bus.req1_valid) begin
         gnt_any  = 1'b1;
         gnt_port = 1'b1;
      end

      sel_we     = gnt_port ? bus.req1_we    : bus.req0_we;
      sel_lock   = gnt_port ? bus.req1_lock  : bus.req0_lock;
      sel_addr   = gnt_port ? bus.req1_addr  : bus.req0_addr;
      sel_wdata  = gnt_port ? bus.req1_wdata : bus.req0_wdata;
      owner_lock = lock_owner ? bus.req1_lock : bus.req0_lock;

      if (gnt_any) begin
         last_gnt_nxt = gnt_port;
         if (!sel_we) begin
            rd_pend_nxt  = 1'b1;
            rd_owner_nxt = gnt_port;
         end
      end

      // owner dropping its lock releases at this edge, valid or not
      if (lock_active) begin
         if (!owner_lock) begin
            lock_active_nxt = 1'b0;
         end
      end else if (gnt_any && sel_lock) begin
         lock_active_nxt = 1'b1;
         lock_owner_nxt  = gnt_port;
      end
   end

   // Outputs: handshake and memory drive from the grant, gated off during reset; responses from read tracking.
   always_comb begin
      bus.req0_ready = 1'b0;
      bus.req1_ready = 1'b0;
      bus.mem_re     = 1'b0;
      bus.mem_raddr  = '0;
      bus.mem_we     = 1'b0;
      bus.mem_waddr  = '0;
      bus.mem_wdata  = '0;

      if (!rst && gnt_any) begin
         bus.req0_ready = ~gnt_port;
         bus.req1_ready = gnt_port;
         if (sel_we) begin
            bus.mem_we    = 1'b1;
            bus.mem_waddr = sel_addr;
            bus.mem_wdata = sel_wdata;
         end else begin
            bus.mem_re    = 1'b1;
            bus.mem_raddr = sel_addr;
         end
      end

      bus.rsp0_valid = rd_pend & ~rd_owner;
      bus.rsp1_valid = rd_pend & rd_owner;
      bus.rsp0_rdata = bus.mem_rdata;
      bus.rsp1_rdata = bus.mem_rdata;
   end

endmodule
